// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: picks the first asserted request scanning upward
// from ptr (inclusive), wrapping at NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       any
);

  localparam int ID_W = $clog2(NUM_REQ);

  int              idx;
  logic [ID_W-1:0] cand;

  // Scan offsets from farthest to nearest so the requester closest to ptr is
  // the last one written and therefore wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves it unassigned and no latch is inferred.
    gnt_id = ptr;
    any    = |req;
    idx    = 0;
    cand   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = ID_W'(idx);
      if (req[cand]) begin
        gnt_id = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant lasts until the owner's last word or MAX_BURST words, whichever
// comes first; one IDLE cycle separates consecutive grants.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         wr_full,
  output logic                         wr_en,
  output logic [DATA_SIZE-1:0]         wr_data,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [ID_W-1:0]   pick_id;
  logic              pick_any;
  logic              xfer;
  logic              burst_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // A word moves only for the current owner and only while the FIFO has room.
  always_comb begin
    xfer      = (state_q == GRANT) && req_valid[grant_id_q] && !wr_full;
    burst_end = req_last[grant_id_q] || (beat_cnt_q == LAST_BEAT);
  end

  // Handshake and write-port muxing; data is passed through, never used for control.
  always_comb begin
    req_ready = '0;
    wr_en     = xfer;
    wr_data   = '0;
    if (state_q == GRANT) begin
      req_ready[grant_id_q] = !wr_full;
    end
    if (xfer) begin
      wr_data = req_data[32'(grant_id_q) * DATA_SIZE +: DATA_SIZE];
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = GRANT;
          grant_id_d = pick_id;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (burst_end) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any grant in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // independent of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign busy     = (state_q == GRANT);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a rotating-priority vector table
// followed by directed multi-cycle sequences checked against a scoreboard.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              wr_full;
  logic              wr_en;
  logic [DW-1:0]     wr_data;
  logic [1:0]        grant_id;
  logic              busy;

  fifo_wr_arbiter #(
    .DATA_SIZE (DW),
    .NUM_REQ   (NR),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wr_full   (wr_full),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int id; logic [DW-1:0] data; logic last; } src_t;
  typedef struct { logic [1:0] id; logic [DW-1:0] data; } exp_t;
  typedef struct { logic [NR-1:0] mask; logic [1:0] exp_id; } vec_t;

  src_t          src[$];
  exp_t          sb[$];
  int            wr_cyc[$];
  logic [NR-1:0] hold;
  int            cyc;
  int            checks;
  int            errors;

  logic          s_wr_en;
  logic          s_busy;
  logic [NR-1:0] s_ready;
  logic [1:0]    s_gid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_src(input int id, input logic [DW-1:0] data, input logic last);
    src_t s;
    s.id = id; s.data = data; s.last = last;
    src.push_back(s);
  endtask

  task automatic push_exp(input int id, input logic [DW-1:0] data);
    exp_t e;
    e.id = 2'(id); e.data = data;
    sb.push_back(e);
  endtask

  // One clock: drive producer heads, sample at negedge, retire accepted words.
  task automatic tick();
    logic [NR-1:0]    v, l, seen, fire;
    logic [NR*DW-1:0] d;
    exp_t             e;
    v = '0; l = '0; d = '0; seen = '0;
    foreach (src[k]) begin
      if (!seen[src[k].id]) begin
        seen[src[k].id] = 1'b1;
        if (!hold[src[k].id]) begin
          v[src[k].id] = 1'b1;
          l[src[k].id] = src[k].last;
          d[src[k].id*DW +: DW] = src[k].data;
        end
      end
    end
    req_valid = v;
    req_last  = l;
    req_data  = d;
    @(negedge clk);
    s_wr_en = wr_en;
    s_busy  = busy;
    s_ready = req_ready;
    s_gid   = grant_id;
    fire    = req_valid & req_ready;
    check("handshake_vs_wr_en", 32'(|fire), 32'(wr_en));
    if (wr_en) begin
      check("no_write_while_full", 32'(wr_full), 32'd0);
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data 0x%0h id %0d, expected no write", wr_data, grant_id);
      end else begin
        e = sb.pop_front();
        check("sb_grant_id", 32'(grant_id), 32'(e.id));
        check("sb_wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (fire[i]) begin
        for (int k = 0; k < src.size(); k++) begin
          if (src[k].id == i) begin
            src.delete(k);
            break;
          end
        end
      end
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((src.size() != 0 || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(src.size() + sb.size()), 32'd0);
  endtask

  task automatic run_until_writes(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (wr_cyc.size() < target && n < budget) begin
      tick();
      n++;
    end
    check({name, "_reached"}, 32'(wr_cyc.size()), 32'(target));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src.delete();
    sb.delete();
    wr_cyc.delete();
    hold = '0;
    wr_full = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   start;
    checks = 0; errors = 0; cyc = 0;
    hold = '0;

    // Reset state, with every producer requesting to show outputs stay quiet.
    rst_n = 1'b0; wr_full = 1'b0;
    req_valid = '1; req_last = '1; req_data = '1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    do_reset();

    // Arbitration table: 1-word packets, rr_ptr history starts at 0.
    vecs[0] = '{4'b0010, 2'd1};
    vecs[1] = '{4'b0011, 2'd0};
    vecs[2] = '{4'b1001, 2'd3};
    vecs[3] = '{4'b1111, 2'd0};
    vecs[4] = '{4'b0001, 2'd0};
    vecs[5] = '{4'b1100, 2'd2};
    vecs[6] = '{4'b0100, 2'd2};
    vecs[7] = '{4'b0110, 2'd1};
    vecs[8] = '{4'b1000, 2'd3};
    for (int v = 0; v < 9; v++) begin
      req_valid = vecs[v].mask;
      req_last  = '1;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 8'((v << 4) | i);
      @(negedge clk);
      check("tbl_idle_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("tbl_busy", 32'(busy), 32'd1);
      check("tbl_grant_id", 32'(grant_id), 32'(vecs[v].exp_id));
      check("tbl_wr_en", 32'(wr_en), 32'd1);
      check("tbl_wr_data", 32'(wr_data), 32'((v << 4) | vecs[v].exp_id));
      check("tbl_req_ready", 32'(req_ready), 32'(1 << vecs[v].exp_id));
      @(posedge clk);
      #1;
      req_valid = '0;
    end

    // Single producer, three-word packet.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_src(1, 8'(17 * (k + 1)), k == 2);
      push_exp(1, 8'(17 * (k + 1)));
    end
    start = cyc;
    drain("single", 20);
    check("single_writes", 32'(wr_cyc.size()), 32'd3);
    if (wr_cyc.size() >= 3) begin
      check("single_latency", 32'(wr_cyc[0] - start), 32'd1);
      check("single_back_to_back", 32'(wr_cyc[2] - wr_cyc[0]), 32'd2);
    end
    tick();
    check("single_release", 32'(s_busy), 32'd0);

    // Burst cap: sole requester, 10 words, never last.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      push_src(0, 8'(8'h40 + k), 1'b0);
      push_exp(0, 8'(8'h40 + k));
    end
    drain("burst", 40);
    check("burst_writes", 32'(wr_cyc.size()), 32'd10);
    for (int i = 1; i < wr_cyc.size(); i++) begin
      check("burst_gap", 32'(wr_cyc[i] - wr_cyc[i-1]), (i % MB == 0) ? 32'd2 : 32'd1);
    end
    check("burst_lock_busy", 32'(busy), 32'd1);
    check("burst_lock_id", 32'(grant_id), 32'd0);

    // Fairness: all four continuously valid with 1-word packets.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) push_src(i, 8'(8'h80 + 16 * i + r), 1'b1);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) push_exp(i, 8'(8'h80 + 16 * i + r));
    end
    drain("fair", 40);
    check("fair_writes", 32'(wr_cyc.size()), 32'd8);
    for (int i = 1; i < wr_cyc.size(); i++) begin
      check("fair_gap", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd2);
    end

    // Full stall mid-burst.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_src(2, 8'(8'hC0 + k), k == 3);
      push_exp(2, 8'(8'hC0 + k));
    end
    run_until_writes("stall_pre", 2, 10);
    wr_full = 1'b1;
    repeat (5) begin
      tick();
      check("stall_wr_en", 32'(s_wr_en), 32'd0);
      check("stall_ready", 32'(s_ready), 32'd0);
      check("stall_grant_id", 32'(s_gid), 32'd2);
      check("stall_busy", 32'(s_busy), 32'd1);
    end
    wr_full = 1'b0;
    tick();
    check("stall_resume_write", 32'(s_wr_en), 32'd1);
    drain("stall", 10);
    check("stall_writes", 32'(wr_cyc.size()), 32'd4);

    // Owner bubble while requester 3 waits.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_src(1, 8'(8'h50 + k), k == 3);
      push_exp(1, 8'(8'h50 + k));
    end
    push_src(3, 8'h3A, 1'b1);
    push_exp(3, 8'h3A);
    run_until_writes("bubble_pre", 1, 10);
    hold[1] = 1'b1;
    repeat (3) begin
      tick();
      check("bubble_busy", 32'(s_busy), 32'd1);
      check("bubble_grant_id", 32'(s_gid), 32'd1);
      check("bubble_ready", 32'(s_ready), 32'b0010);
      check("bubble_wr_en", 32'(s_wr_en), 32'd0);
    end
    hold[1] = 1'b0;
    drain("bubble", 20);
    check("bubble_writes", 32'(wr_cyc.size()), 32'd5);

    // Reset mid-burst: owner 2 with two beats done.
    do_reset();
    for (int k = 0; k < 4; k++) push_src(2, 8'(8'hE0 + k), k == 3);
    push_exp(2, 8'hE0);
    push_exp(2, 8'hE1);
    run_until_writes("rst_pre", 2, 10);
    check("rst_mid_owner", 32'(grant_id), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wr_en", 32'(wr_en), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd0);
    repeat (2) begin
      tick();
      check("rst_hold_wr_en", 32'(s_wr_en), 32'd0);
    end
    src.delete();
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      check("rst_after_idle", 32'(s_busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
